// File: rtl/key_tone_generator.sv
// Square-wave tone generator: the highest pressed key picks one of eight notes (C4..C5).
// Define KEY_TONE_SUSTAIN_EN to let the tone ring for SUSTAIN cycles after release.
module key_tone_generator #(
  parameter int DIVWIDTH = 17,
  parameter int DIVSHIFT = 0,
  parameter int SUSTAIN  = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] conditioned,
  output logic       speaker,
  output logic       playing,
  output logic [2:0] note
);

`ifdef KEY_TONE_SUSTAIN_EN
  typedef enum logic [1:0] {IDLE, PLAY, SUST} state_t;
  logic [24:0] hold, hold_n;
`else
  typedef enum logic [1:0] {IDLE, PLAY} state_t;
`endif

  localparam int H [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

  function automatic logic [DIVWIDTH-1:0] hs_m1(input logic [2:0] i);
    return DIVWIDTH'(H[i] >> DIVSHIFT) - DIVWIDTH'(1);
  endfunction

  state_t              state, state_n;
  logic [DIVWIDTH-1:0] cnt, cnt_n;
  logic [2:0]          note_n, sel;
  logic                spk_n, play_n, any;
  logic                restart, tick, go_idle;

  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < 8; i++)
      if (conditioned[i]) sel = 3'(i);
  end
  assign any = |conditioned;

  always_comb begin
    state_n = state;
    note_n  = note;
    cnt_n   = cnt;
    spk_n   = speaker;
    play_n  = playing;
    restart = 1'b0;
    tick    = 1'b0;
    go_idle = 1'b0;
`ifdef KEY_TONE_SUSTAIN_EN
    hold_n  = hold;
`endif
    case (state)
      IDLE: begin
        go_idle = 1'b1;
        if (any) begin
          go_idle = 1'b0;
          restart = 1'b1;
          state_n = PLAY;
        end
      end
      PLAY: begin
        if (!any) begin
`ifdef KEY_TONE_SUSTAIN_EN
          state_n = SUST;
          hold_n  = 25'(SUSTAIN - 1);
          tick    = 1'b1;
`else
          state_n = IDLE;
          go_idle = 1'b1;
`endif
        end else if (sel != note) restart = 1'b1;
        else                      tick    = 1'b1;
      end
`ifdef KEY_TONE_SUSTAIN_EN
      SUST: begin
        if (any) begin
          state_n = PLAY;
          if (sel != note) restart = 1'b1;
          else             tick    = 1'b1;
        end else if (hold == '0) begin
          state_n = IDLE;
          go_idle = 1'b1;
        end else begin
          hold_n = hold - 25'd1;
          tick   = 1'b1;
        end
      end
`endif
      default: state_n = IDLE;
    endcase

    // Datapath actions chosen above; restart resets the phase to a low half-period.
    if (go_idle) begin
      spk_n  = 1'b0;
      play_n = 1'b0;
      cnt_n  = '0;
    end else if (restart) begin
      note_n = sel;
      cnt_n  = hs_m1(sel);
      spk_n  = 1'b0;
      play_n = 1'b1;
    end else if (tick) begin
      if (cnt == '0) begin
        spk_n = ~speaker;
        cnt_n = hs_m1(note);
      end else begin
        cnt_n = cnt - DIVWIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      note    <= 3'd0;
      cnt     <= '0;
      speaker <= 1'b0;
      playing <= 1'b0;
`ifdef KEY_TONE_SUSTAIN_EN
      hold    <= '0;
`endif
    end else begin
      state   <= state_n;
      note    <= note_n;
      cnt     <= cnt_n;
      speaker <= spk_n;
      playing <= play_n;
`ifdef KEY_TONE_SUSTAIN_EN
      hold    <= hold_n;
`endif
    end
  end

endmodule
